// File: rtl/acl_header_parser_if.sv
// acl_header_parser_if: frame stream in, header record out, for the ACL header parser
interface acl_header_parser_if #(parameter int CNT_W = 16) ();
  logic [31:0]      i_rxd_tdata;
  logic             i_rxd_tvalid;
  logic             i_rxd_tlast;
  logic             o_rxd_tready;
  logic             o_hdr_valid;
  logic             i_hdr_ready;
  logic [47:0]      o_dst_mac;
  logic [47:0]      o_src_mac;
  logic [15:0]      o_ethertype;
  logic [7:0]       o_ip_proto;
  logic [31:0]      o_src_ip;
  logic [31:0]      o_dst_ip;
  logic [15:0]      o_src_port;
  logic [15:0]      o_dst_port;
  logic             o_ip_ok;
  logic             o_l4_valid;
  logic             o_runt;
  logic [CNT_W-1:0] o_frame_beats;
  modport master (
    input  i_rxd_tdata, i_rxd_tvalid, i_rxd_tlast, i_hdr_ready,
    output o_rxd_tready, o_hdr_valid, o_dst_mac, o_src_mac, o_ethertype, o_ip_proto,
           o_src_ip, o_dst_ip, o_src_port, o_dst_port, o_ip_ok, o_l4_valid, o_runt, o_frame_beats
  );
  modport slave (
    output i_rxd_tdata, i_rxd_tvalid, i_rxd_tlast, i_hdr_ready,
    input  o_rxd_tready, o_hdr_valid, o_dst_mac, o_src_mac, o_ethertype, o_ip_proto,
           o_src_ip, o_dst_ip, o_src_port, o_dst_port, o_ip_ok, o_l4_valid, o_runt, o_frame_beats
  );
endinterface

// File: rtl/acl_header_parser.sv
// acl_header_parser: pulls L2/L3/L4 ACL fields out of a 32-bit Ethernet stream, one record per frame
module acl_header_parser #(
  parameter int          CNT_W          = 16,
  parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800
) (
  input logic                 clk,
  input logic                 rst,
  acl_header_parser_if.master bus
);
  typedef enum logic [1:0] {PARSE, DRAIN, HOLD} state_t;
  state_t           r_state, w_next;
  logic             r_run;
  logic [3:0]       r_widx;
  logic [CNT_W-1:0] r_beats;
  logic [47:0]      r_dst_mac, r_src_mac;
  logic [15:0]      r_ethertype, r_src_port, r_dst_port;
  logic [3:0]       r_version, r_ihl;
  logic [7:0]       r_ip_proto;
  logic [31:0]      r_src_ip, r_dst_ip;
  logic             r_runt, r_ip_ok, r_l4_valid;
  logic [31:0]      w_d;
  logic             w_beat, w_accept, w_runt, w_ip_ok, w_l4_valid;
  assign w_d        = bus.i_rxd_tdata;
  assign w_beat     = bus.i_rxd_tvalid && bus.o_rxd_tready;
  assign w_accept   = r_state == HOLD && bus.i_hdr_ready;
  // flags are judged on the tlast beat from the index of that beat; a frame shorter than 9 beats is a runt
  assign w_runt     = r_widx < 4'd8;
  assign w_ip_ok    = !w_runt && r_ethertype == ETHERTYPE_IPV4 && r_version == 4'd4 && r_ihl == 4'd5;
  assign w_l4_valid = w_ip_ok && (r_ip_proto == 8'd6 || r_ip_proto == 8'd17) && r_widx >= 4'd9;
  // state register; r_run holds tready low until the first clock after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= PARSE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  // next state: tlast always ends in HOLD, a non-last beat 9 moves on to DRAIN
  always_comb
    w_next = (r_state == HOLD) ? (bus.i_hdr_ready ? PARSE : HOLD) :
             (w_beat && bus.i_rxd_tlast) ? HOLD :
             (r_state == PARSE && w_beat && r_widx == 4'd9) ? DRAIN : r_state;
  // handshake outputs decoded from state
  always_comb begin
    bus.o_rxd_tready = r_run && r_state != HOLD;
    bus.o_hdr_valid  = r_state == HOLD;
  end
  assign bus.o_dst_mac     = r_dst_mac;
  assign bus.o_src_mac     = r_src_mac;
  assign bus.o_ethertype   = r_ethertype;
  assign bus.o_ip_proto    = r_ip_proto;
  assign bus.o_src_ip      = r_src_ip;
  assign bus.o_dst_ip      = r_dst_ip;
  assign bus.o_src_port    = r_src_port;
  assign bus.o_dst_port    = r_dst_port;
  assign bus.o_ip_ok       = r_ip_ok;
  assign bus.o_l4_valid    = r_l4_valid;
  assign bus.o_runt        = r_runt;
  assign bus.o_frame_beats = r_beats;
  // capture fields by beat index; everything clears when the record is taken so missing beats read 0
  always_ff @(posedge clk or posedge rst)
    if (rst || w_accept) begin
      r_widx      <= '0;
      r_beats     <= '0;
      r_dst_mac   <= '0;
      r_src_mac   <= '0;
      r_ethertype <= '0;
      r_version   <= '0;
      r_ihl       <= '0;
      r_ip_proto  <= '0;
      r_src_ip    <= '0;
      r_dst_ip    <= '0;
      r_src_port  <= '0;
      r_dst_port  <= '0;
      r_runt      <= 1'b0;
      r_ip_ok     <= 1'b0;
      r_l4_valid  <= 1'b0;
    end else if (w_beat) begin
      r_widx  <= r_widx + {3'd0, r_widx != 4'd10};
      r_beats <= r_beats + {{(CNT_W-1){1'b0}}, ~&r_beats};
      case (r_widx)
        4'd0: r_dst_mac[47:16] <= w_d;
        4'd1: begin
          r_dst_mac[15:0]  <= w_d[31:16];
          r_src_mac[47:32] <= w_d[15:0];
        end
        4'd2: r_src_mac[31:0] <= w_d;
        4'd3: begin
          r_ethertype <= w_d[31:16];
          r_version   <= w_d[15:12];
          r_ihl       <= w_d[11:8];
        end
        4'd5: r_ip_proto <= w_d[7:0];
        4'd6: r_src_ip[31:16] <= w_d[15:0];
        4'd7: begin
          r_src_ip[15:0]  <= w_d[31:16];
          r_dst_ip[31:16] <= w_d[15:0];
        end
        4'd8: begin
          r_dst_ip[15:0] <= w_d[31:16];
          r_src_port     <= w_d[15:0];
        end
        4'd9: r_dst_port <= w_d[31:16];
        default: ;
      endcase
      if (bus.i_rxd_tlast) begin
        r_runt     <= w_runt;
        r_ip_ok    <= w_ip_ok;
        r_l4_valid <= w_l4_valid;
      end
    end
endmodule

// File: tb/tb_acl_header_parser.sv
// tb_acl_header_parser: directed frames with hand-computed header records
module tb_acl_header_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] fr [0:127];
  acl_header_parser_if #(.CNT_W(16)) bus ();
  acl_header_parser dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task build(input int kind);
    fr[0] = 32'h8000_207A; fr[1] = 32'h3F3E_8000; fr[2] = 32'h2020_3AAE;
    fr[3] = 32'h0800_AAAA; fr[4] = 32'hBBBB_BBBB; fr[5] = 32'hCCCC_9906;
    fr[6] = 32'hDDDD_DDDD; fr[7] = 32'hFFFF_BAAA; fr[8] = 32'hBBBB_CCCC;
    for (int i = 9; i < 128; i++) fr[i] = $urandom;
    if (kind >= 1) begin
      fr[3] = 32'h0800_4500;
      fr[9] = {16'h1F90, 16'($urandom)};
    end
    if (kind == 2) fr[5] = 32'hCCCC_9911;
    if (kind == 3) fr[5] = 32'hCCCC_9901;
  endtask
  task beat(input logic [31:0] d, input bit last);
    int k;
    bus.i_rxd_tdata  = d;
    bus.i_rxd_tvalid = 1'b1;
    bus.i_rxd_tlast  = last;
    k = 0;
    while (!bus.o_rxd_tready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) chk("tready_timeout", 64'(bus.o_rxd_tready), 64'd1);
    @(posedge clk);
    #1;
    bus.i_rxd_tvalid = 1'b0;
    bus.i_rxd_tlast  = 1'b0;
    bus.i_rxd_tdata  = 'x;
  endtask
  task send_frame(input int n);
    for (int i = 0; i < n; i++) beat(fr[i], i == n - 1);
  endtask
  task accept();
    bus.i_hdr_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_hdr_ready = 1'b0;
    @(negedge clk);
    chk("valid_dropped", 64'(bus.o_hdr_valid), 64'd0);
    chk("tready_after_accept", 64'(bus.o_rxd_tready), 64'd1);
  endtask
  initial begin
    bus.i_rxd_tdata  = '0;
    bus.i_rxd_tvalid = 1'b0;
    bus.i_rxd_tlast  = 1'b0;
    bus.i_hdr_ready  = 1'b0;
    #12;
    chk("rst_tready", 64'(bus.o_rxd_tready), 64'd0);
    chk("rst_valid", 64'(bus.o_hdr_valid), 64'd0);
    chk("rst_beats", 64'(bus.o_frame_beats), 64'd0);
    chk("rst_dst_mac", 64'(bus.o_dst_mac), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", 64'(bus.o_rxd_tready), 64'd1);
    // standard frame, version A so not IPv4
    build(0);
    send_frame(100);
    @(negedge clk);
    chk("std_valid", 64'(bus.o_hdr_valid), 64'd1);
    chk("std_dst_mac", 64'(bus.o_dst_mac), 64'h8000207A3F3E);
    chk("std_src_mac", 64'(bus.o_src_mac), 64'h800020203AAE);
    chk("std_ethertype", 64'(bus.o_ethertype), 64'h0800);
    chk("std_proto", 64'(bus.o_ip_proto), 64'h06);
    chk("std_src_ip", 64'(bus.o_src_ip), 64'hDDDDFFFF);
    chk("std_dst_ip", 64'(bus.o_dst_ip), 64'hBAAABBBB);
    chk("std_src_port", 64'(bus.o_src_port), 64'hCCCC);
    chk("std_ip_ok", 64'(bus.o_ip_ok), 64'd0);
    chk("std_l4", 64'(bus.o_l4_valid), 64'd0);
    chk("std_runt", 64'(bus.o_runt), 64'd0);
    chk("std_beats", 64'(bus.o_frame_beats), 64'd100);
    chk("std_tready_hold", 64'(bus.o_rxd_tready), 64'd0);
    accept();
    // valid IPv4/TCP
    build(1);
    send_frame(100);
    @(negedge clk);
    chk("tcp_ip_ok", 64'(bus.o_ip_ok), 64'd1);
    chk("tcp_l4", 64'(bus.o_l4_valid), 64'd1);
    chk("tcp_dst_port", 64'(bus.o_dst_port), 64'h1F90);
    accept();
    // UDP
    build(2);
    send_frame(100);
    @(negedge clk);
    chk("udp_proto", 64'(bus.o_ip_proto), 64'h11);
    chk("udp_l4", 64'(bus.o_l4_valid), 64'd1);
    accept();
    // ICMP: IPv4 ok but no ports
    build(3);
    send_frame(100);
    @(negedge clk);
    chk("icmp_ip_ok", 64'(bus.o_ip_ok), 64'd1);
    chk("icmp_l4", 64'(bus.o_l4_valid), 64'd0);
    accept();
    // 9 beats: full IP header but beat 9 missing
    build(1);
    send_frame(9);
    @(negedge clk);
    chk("b9_runt", 64'(bus.o_runt), 64'd0);
    chk("b9_ip_ok", 64'(bus.o_ip_ok), 64'd1);
    chk("b9_l4", 64'(bus.o_l4_valid), 64'd0);
    chk("b9_dst_port", 64'(bus.o_dst_port), 64'd0);
    chk("b9_beats", 64'(bus.o_frame_beats), 64'd9);
    accept();
    // 10 beats: tlast on index 9, straight to HOLD
    build(1);
    send_frame(10);
    @(negedge clk);
    chk("b10_valid", 64'(bus.o_hdr_valid), 64'd1);
    chk("b10_l4", 64'(bus.o_l4_valid), 64'd1);
    chk("b10_dst_port", 64'(bus.o_dst_port), 64'h1F90);
    chk("b10_beats", 64'(bus.o_frame_beats), 64'd10);
    accept();
    // runt
    build(1);
    send_frame(5);
    @(negedge clk);
    chk("runt_flag", 64'(bus.o_runt), 64'd1);
    chk("runt_ip_ok", 64'(bus.o_ip_ok), 64'd0);
    chk("runt_src_ip", 64'(bus.o_src_ip), 64'd0);
    chk("runt_proto", 64'(bus.o_ip_proto), 64'd0);
    chk("runt_ethertype", 64'(bus.o_ethertype), 64'h0800);
    chk("runt_beats", 64'(bus.o_frame_beats), 64'd5);
    accept();
    // backpressure: second frame waits while the first record is held
    build(1);
    send_frame(12);
    build(2);
    fork
      send_frame(12);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("bp_tready", 64'(bus.o_rxd_tready), 64'd0);
          chk("bp_valid", 64'(bus.o_hdr_valid), 64'd1);
          chk("bp_beats", 64'(bus.o_frame_beats), 64'd12);
          chk("bp_dst_port", 64'(bus.o_dst_port), 64'h1F90);
          chk("bp_proto", 64'(bus.o_ip_proto), 64'h06);
        end
        bus.i_hdr_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_hdr_ready = 1'b0;
        @(negedge clk);
        chk("bp_tready_next", 64'(bus.o_rxd_tready), 64'd1);
      end
    join
    @(negedge clk);
    chk("bp2_valid", 64'(bus.o_hdr_valid), 64'd1);
    chk("bp2_proto", 64'(bus.o_ip_proto), 64'h11);
    chk("bp2_l4", 64'(bus.o_l4_valid), 64'd1);
    chk("bp2_beats", 64'(bus.o_frame_beats), 64'd12);
    chk("bp2_dst_mac", 64'(bus.o_dst_mac), 64'h8000207A3F3E);
    accept();
    // asynchronous reset mid-frame
    build(1);
    for (int i = 0; i < 50; i++) beat(fr[i], 1'b0);
    chk("pre_rst_beats", 64'(bus.o_frame_beats), 64'd50);
    chk("pre_rst_dst_mac", 64'(bus.o_dst_mac), 64'h8000207A3F3E);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.o_hdr_valid), 64'd0);
    chk("arst_beats", 64'(bus.o_frame_beats), 64'd0);
    chk("arst_dst_mac", 64'(bus.o_dst_mac), 64'd0);
    chk("arst_src_ip", 64'(bus.o_src_ip), 64'd0);
    chk("arst_tready", 64'(bus.o_rxd_tready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_tready_released", 64'(bus.o_rxd_tready), 64'd0);
    @(negedge clk);
    chk("arst_tready_next", 64'(bus.o_rxd_tready), 64'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
